univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter STEP, default 1, bit positions moved per shift cycle (1 <= STEP <= WIDTH-1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port ex  input  1  operation enable; 0 means hold all state.
REQ-006 The block SHALL have port mode  input  3  operation select, encoded per REQ-009.
REQ-007 The block SHALL have ports in  input  WIDTH  parallel load data; sin_l  input  1  serial fill bit for left shift; sin_r  input  1  serial fill bit for right shift.
REQ-008 The block SHALL have ports out  output  WIDTH  register contents; sout  output  1  last departing bit; cnt  output  $clog2(WIDTH+1)  bits shifted out since last load; drained  output  1  cnt == WIDTH.

Function
REQ-009 Mode encoding SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR.
REQ-010 With ex=0, out, sout and cnt SHALL hold, regardless of mode.
REQ-011 With ex=1, the update SHALL take effect on the same rising edge; latency is one cycle, and out is visible the cycle after the edge.
REQ-012 LOAD SHALL set out <= in and cnt <= 0; sout holds.
REQ-013 SHL SHALL set out <= {out[WIDTH-1-STEP:0], STEP copies of sin_l}.
REQ-014 SHR SHALL set out <= {STEP copies of sin_r, out[WIDTH-1:STEP]}.
REQ-015 ASR SHALL behave as SHR but fill with the pre-shift out[WIDTH-1]; sin_r is ignored.
REQ-016 ROL and ROR SHALL rotate out by STEP positions left or right, with no bits lost; sin_l and sin_r are ignored.
REQ-017 On SHL and ROL, sout SHALL register the pre-update out[WIDTH-1]; on SHR, ROR and ASR it SHALL register the pre-update out[0]; in all other modes sout holds.
REQ-018 SHL, SHR and ASR SHALL add STEP to cnt, saturating at WIDTH and never wrapping; ROL and ROR SHALL leave cnt unchanged.
REQ-019 CLR SHALL set out <= 0, cnt <= 0 and sout <= 0.
REQ-020 HOLD SHALL change nothing.
REQ-021 drained SHALL be combinational from cnt only, asserting exactly when cnt == WIDTH.
REQ-022 Further shifts while drained SHALL still move data and update sout; cnt stays at WIDTH.
REQ-023 A parameter set violating REQ-001 or REQ-002 SHALL fail elaboration.

Reset
REQ-024 While rst=0 at a rising edge, the next state SHALL be out=0, sout=0 and cnt=0, and therefore drained=0.
REQ-025 Reset SHALL dominate ex and mode; asserting reset mid-shift discards the operation in progress.
REQ-026 No state SHALL change asynchronously on rst; the first operation after release is accepted on the first edge with rst=1.

Structure
REQ-027 The mode encodings and the STEP/WIDTH legality check SHALL live in the shared package shift_pkg.
REQ-028 The next-value selection SHALL be one combinational sub-module, shift_next (inputs out, mode, sin_l, sin_r; outputs next out and departing bit); univ_shift_reg holds the registers and cnt.
REQ-029 The design SHALL contain no latches, and only clk SHALL be used as a clock.

Verification (WIDTH=8, STEP=1 unless stated)
REQ-030 rst=0 for 2 cycles with ex=1, mode=LOAD, in=8'hFF -> out=8'h00, cnt=0, drained=0.
REQ-031 LOAD 8'b0100_0001, then SHL x3 with sin_l=1 -> out=8'b0000_1111, sout=0 then 1 then 0, cnt=3.
REQ-032 LOAD 8'h96, then 8 SHR with sin_r=0 -> out=8'h00, drained=1; a 9th SHR -> cnt stays 8, sout=0.
REQ-033 LOAD 8'h81, then ROR x1 -> out=8'hC0, cnt=0; then ASR x2 -> out=8'hF0, cnt=2.
REQ-034 LOAD 8'hA5, then ex=0 with mode=SHL for 3 cycles -> out=8'hA5, cnt=0; rst=0 during the next SHL -> out=0.
REQ-035 WIDTH=8, STEP=3: LOAD 8'hFF, then SHL x3 with sin_l=0 -> out=8'hF8, then 8'hC0, then 8'h00; cnt=3, 6, then 8 (saturated); drained=1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// elaboration-time helpers for parameter legality and mode classification.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } shift_mode_e;

    localparam int MIN_WIDTH = 2;
    localparam int MIN_STEP  = 1;

    // True when the WIDTH/STEP pair describes a buildable register.
    function automatic bit step_legal(input int width, input int step);
        return (width >= MIN_WIDTH) && (step >= MIN_STEP) && (step <= width - 1);
    endfunction

    function automatic bit mode_counts(input shift_mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ASR);
    endfunction

    function automatic bit mode_departs(input shift_mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ASR) ||
               (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

    // Left-moving operations lose their MSB first; right-moving ones their LSB.
    function automatic bit mode_departs_msb(input shift_mode_e m);
        return (m == MODE_SHL) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_next.sv
// Combinational next-value selection for the shift register datapath:
// produces the post-operation contents and the bit that leaves the register.
module shift_next
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] cur,
    input  shift_mode_e      mode,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] nxt,
    output logic             dep_bit
);

    logic sign_bit;

    assign sign_bit = cur[WIDTH-1];

    always_comb begin
        nxt = cur;
        unique case (mode)
            MODE_SHL: nxt = {cur[WIDTH-1-STEP:0], {STEP{sin_l}}};
            MODE_SHR: nxt = {{STEP{sin_r}}, cur[WIDTH-1:STEP]};
            MODE_ASR: nxt = {{STEP{sign_bit}}, cur[WIDTH-1:STEP]};
            MODE_ROL: nxt = {cur[WIDTH-1-STEP:0], cur[WIDTH-1:WIDTH-STEP]};
            MODE_ROR: nxt = {cur[STEP-1:0], cur[WIDTH-1:STEP]};
            MODE_CLR: nxt = '0;
            default:  nxt = cur;
        endcase
    end

    // Only the edge-most bit is reported even when STEP > 1.
    always_comb begin
        dep_bit = cur[0];
        if (mode_departs_msb(mode)) begin
            dep_bit = cur[WIDTH-1];
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load, logical/arithmetic shift, rotate and clear,
// with a saturating count of bits shifted out since the last load.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             in,
    input  logic                         sin_l,
    input  logic                         sin_r,
    output logic [WIDTH-1:0]             out,
    output logic                         sout,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         drained
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(STEP);

    generate
        if (!step_legal(WIDTH, STEP)) begin : g_bad_params
            $error("univ_shift_reg: WIDTH must be >= 2 and STEP in [1, WIDTH-1]");
        end
    endgenerate

    // Never wraps: STEP < WIDTH keeps CNT_SAT - CNT_INC non-negative.
    function automatic logic [CNT_W-1:0] sat_add_step(input logic [CNT_W-1:0] c);
        if (c >= CNT_SAT - CNT_INC) begin
            return CNT_SAT;
        end
        return c + CNT_INC;
    endfunction

    shift_mode_e      mode_e;
    logic [WIDTH-1:0] shift_nxt;
    logic             dep_bit;

    logic [WIDTH-1:0] out_p0;
    logic             sout_p0;
    logic [CNT_W-1:0] cnt_p0;

    logic [WIDTH-1:0] out_p1;
    logic             sout_p1;
    logic [CNT_W-1:0] cnt_p1;

    assign mode_e = shift_mode_e'(mode);

    shift_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shift_next (
        .cur     (out_p1),
        .mode    (mode_e),
        .sin_l   (sin_l),
        .sin_r   (sin_r),
        .nxt     (shift_nxt),
        .dep_bit (dep_bit)
    );

    // Stage p0: next state selection
    always_comb begin
        out_p0  = out_p1;
        sout_p0 = sout_p1;
        cnt_p0  = cnt_p1;
        if (ex) begin
            unique case (mode_e)
                MODE_HOLD: ;
                MODE_LOAD: begin
                    out_p0 = in;
                    cnt_p0 = '0;
                end
                MODE_CLR: begin
                    out_p0  = '0;
                    sout_p0 = 1'b0;
                    cnt_p0  = '0;
                end
                default: begin
                    out_p0 = shift_nxt;
                    if (mode_departs(mode_e)) begin
                        sout_p0 = dep_bit;
                    end
                    if (mode_counts(mode_e)) begin
                        cnt_p0 = sat_add_step(cnt_p1);
                    end
                end
            endcase
        end
    end

    // Stage p1: architectural state
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_p1  <= '0;
            sout_p1 <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            out_p1  <= out_p0;
            sout_p1 <= sout_p0;
            cnt_p1  <= cnt_p0;
        end
    end

    assign out     = out_p1;
    assign sout    = sout_p1;
    assign cnt     = cnt_p1;
    assign drained = (cnt_p1 == CNT_SAT);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: one STEP=1 instance and one STEP=3
// instance, each step checked with an immediate assertion.
module tb_univ_shift_reg;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst;

    logic       ex;
    logic [2:0] mode;
    logic [7:0] din;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] out;
    logic       sout;
    logic [3:0] cnt;
    logic       drained;

    logic       ex3;
    logic [2:0] mode3;
    logic [7:0] din3;
    logic       sin_l3;
    logic       sin_r3;
    logic [7:0] out3;
    logic       sout3;
    logic [3:0] cnt3;
    logic       drained3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .STEP(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .ex      (ex),
        .mode    (mode),
        .in      (din),
        .sin_l   (sin_l),
        .sin_r   (sin_r),
        .out     (out),
        .sout    (sout),
        .cnt     (cnt),
        .drained (drained)
    );

    univ_shift_reg #(.WIDTH(8), .STEP(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .ex      (ex3),
        .mode    (mode3),
        .in      (din3),
        .sin_l   (sin_l3),
        .sin_r   (sin_r3),
        .out     (out3),
        .sout    (sout3),
        .cnt     (cnt3),
        .drained (drained3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one operation to the STEP=1 instance, then sample after the edge.
    task automatic op(input logic e, input logic [2:0] m, input logic [7:0] d,
                      input logic sl, input logic sr);
        ex    = e;
        mode  = m;
        din   = d;
        sin_l = sl;
        sin_r = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic op3(input logic [2:0] m, input logic [7:0] d, input logic sl);
        ex3    = 1'b1;
        mode3  = m;
        din3   = d;
        sin_l3 = sl;
        sin_r3 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ex = 1'b1; mode = MODE_LOAD; din = 8'hFF; sin_l = 1'b0; sin_r = 1'b0;
        ex3 = 1'b1; mode3 = MODE_LOAD; din3 = 8'hFF; sin_l3 = 1'b0; sin_r3 = 1'b0;

        // Reset held two cycles while a LOAD of FF is requested.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out", out, 8'h00);
        chk("rst_cnt", cnt, 4'd0);
        chk("rst_drained", drained, 1'b0);
        chk("rst_sout", sout, 1'b0);
        chk("rst_out3", out3, 8'h00);
        rst = 1'b1;
        ex3 = 1'b0;

        // LOAD then three SHL with sin_l=1.
        op(1'b1, MODE_LOAD, 8'b0100_0001, 1'b0, 1'b0);
        chk("load41_out", out, 8'h41);
        op(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        chk("shl1_out", out, 8'h83);
        chk("shl1_sout", sout, 1'b0);
        chk("shl1_cnt", cnt, 4'd1);
        op(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        chk("shl2_out", out, 8'h07);
        chk("shl2_sout", sout, 1'b1);
        op(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        chk("shl3_out", out, 8'h0F);
        chk("shl3_sout", sout, 1'b0);
        chk("shl3_cnt", cnt, 4'd3);

        // Drain 96 with SHR, then one extra SHR past saturation.
        op(1'b1, MODE_LOAD, 8'h96, 1'b0, 1'b0);
        chk("load96_cnt", cnt, 4'd0);
        op(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
        chk("shr1_out", out, 8'h4B);
        chk("shr1_sout", sout, 1'b0);
        for (int i = 0; i < 6; i++) op(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
        chk("shr7_cnt", cnt, 4'd7);
        chk("shr7_drained", drained, 1'b0);
        op(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
        chk("shr8_out", out, 8'h00);
        chk("shr8_cnt", cnt, 4'd8);
        chk("shr8_drained", drained, 1'b1);
        chk("shr8_sout", sout, 1'b1);
        op(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
        chk("shr9_cnt", cnt, 4'd8);
        chk("shr9_sout", sout, 1'b0);
        chk("shr9_drained", drained, 1'b1);

        // Rotate right, then arithmetic shifts, then rotate left.
        op(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        op(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b1);
        chk("ror_out", out, 8'hC0);
        chk("ror_cnt", cnt, 4'd0);
        chk("ror_sout", sout, 1'b1);
        op(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b0);
        chk("asr1_out", out, 8'hE0);
        op(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b0);
        chk("asr2_out", out, 8'hF0);
        chk("asr2_cnt", cnt, 4'd2);
        chk("asr2_sout", sout, 1'b0);
        op(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
        chk("rol_out", out, 8'hE1);
        chk("rol_sout", sout, 1'b1);
        chk("rol_cnt", cnt, 4'd2);

        // ex=0 holds everything; reset then kills an in-flight SHL.
        op(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
        chk("loadA5_sout", sout, 1'b1);
        for (int i = 0; i < 3; i++) op(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b1);
        chk("hold_ex_out", out, 8'hA5);
        chk("hold_ex_cnt", cnt, 4'd0);
        chk("hold_ex_sout", sout, 1'b1);
        rst = 1'b0;
        op(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        chk("midrst_out", out, 8'h00);
        chk("midrst_sout", sout, 1'b0);
        rst = 1'b1;
        op(1'b1, MODE_LOAD, 8'h3D, 1'b0, 1'b0);
        chk("post_rst_load", out, 8'h3D);

        // HOLD mode with ex=1, then CLR.
        op(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
        chk("ror3d_out", out, 8'h9E);
        op(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
        chk("shr_fill1", out, 8'hCF);
        op(1'b1, MODE_HOLD, 8'h55, 1'b1, 1'b1);
        chk("hold_out", out, 8'hCF);
        chk("hold_cnt", cnt, 4'd1);
        op(1'b1, MODE_CLR, 8'h55, 1'b1, 1'b1);
        chk("clr_out", out, 8'h00);
        chk("clr_cnt", cnt, 4'd0);
        chk("clr_sout", sout, 1'b0);
        ex = 1'b0;

        // STEP=3 instance: multi-bit shifts and saturation.
        op3(MODE_LOAD, 8'hFF, 1'b0);
        op3(MODE_SHL, 8'h00, 1'b0);
        chk("s3_shl1_out", out3, 8'hF8);
        chk("s3_shl1_cnt", cnt3, 4'd3);
        chk("s3_shl1_sout", sout3, 1'b1);
        op3(MODE_SHL, 8'h00, 1'b0);
        chk("s3_shl2_out", out3, 8'hC0);
        chk("s3_shl2_cnt", cnt3, 4'd6);
        chk("s3_shl2_drained", drained3, 1'b0);
        op3(MODE_SHL, 8'h00, 1'b0);
        chk("s3_shl3_out", out3, 8'h00);
        chk("s3_shl3_cnt", cnt3, 4'd8);
        chk("s3_shl3_drained", drained3, 1'b1);
        op3(MODE_LOAD, 8'h81, 1'b0);
        op3(MODE_ROR, 8'h00, 1'b0);
        chk("s3_ror_out", out3, 8'h30);
        op3(MODE_LOAD, 8'h80, 1'b0);
        op3(MODE_ASR, 8'h00, 1'b0);
        chk("s3_asr_out", out3, 8'hF0);
        chk("s3_asr_cnt", cnt3, 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
